vector_mem_sequencer: RTL and testbench

- Memory-stage controller that splits one 128-bit vector load or store into LANES sequential 32-bit accesses on the external word-wide data memory.
- Holds the pipeline via stall until all beats finish, then presents the assembled vector as load data.
- Scalar accesses pass straight through with no stall.
- Sits between the execution/memory pipe outputs and the data memory port; stall feeds the pipeline stall network.

---
 rtl/vector_mem_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: splits a vector load/store into LANES word beats on a word-wide data memory.
// Optional build macro VSEQ_ALIGN_CHECK_EN adds a misaligned-vector-request check and an err output.
module vector_mem_sequencer #(
    parameter int              N        = 32,
    parameter int              V        = 128,
    parameter int              LANES    = 4,
    parameter logic [N-1:0]    ADDR_MAX = 32'h30D3F
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vect_m,
    input  logic            memw_m,
    input  logic            memtoreg_m,
    input  logic [N-1:0]    addr_m,
    input  logic [V-1:0]    wdata_m,
    input  logic [N-1:0]    mem_rdata,
    output logic [N-1:0]    mem_addr,
    output logic [N-1:0]    mem_wdata,
    output logic            mem_we,
    output logic [V-1:0]    rdata_m,
    output logic            stall,
    output logic            busy,
    output logic            done
`ifdef VSEQ_ALIGN_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam int BW = $clog2(LANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [N-1:0]   base_q, base_d;
    logic [V-1:0]   wdata_q, wdata_d;
    logic           store_q, store_d;
    logic [V-1:0]   result_q, result_d;

    logic           req;
    logic           misalign;
    logic [N-1:0]   beat_addr;

    // Addresses past the end of data memory are forced to 0 rather than wrapping into it.
    function automatic logic [N-1:0] clamp_addr(input logic [N-1:0] a);
        return (a > ADDR_MAX) ? '0 : a;
    endfunction

    assign req       = vect_m & (memw_m | memtoreg_m);
    assign beat_addr = base_q + (N'(beat_q) << 2);

`ifdef VSEQ_ALIGN_CHECK_EN
    logic err_q, err_d;

    assign misalign = (addr_m[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && req) begin
            err_d = misalign;
        end
    end

    assign err = done & err_q;
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always retires to IDLE so the finishing instruction cannot re-trigger.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = misalign ? DONE : BEAT;
                end
            end
            BEAT: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q   <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            result_q <= '0;
        end else begin
            beat_q   <= beat_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            result_q <= result_d;
        end
    end

    // Request inputs are latched once in IDLE; later beats only use the latched copies.
    always_comb begin
        beat_d   = beat_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    beat_d   = '0;
                    base_d   = addr_m;
                    wdata_d  = wdata_m;
                    store_d  = memw_m;
                    result_d = '0;
                end
            end
            BEAT: begin
                if (!store_q) begin
                    result_d[int'(beat_q)*N +: N] = mem_rdata;
                end
                beat_d = beat_q + 1'b1;
            end
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        mem_addr  = clamp_addr(addr_m);
        mem_wdata = wdata_m[N-1:0];
        mem_we    = 1'b0;
        rdata_m   = {LANES{mem_rdata}};
        stall     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    stall = 1'b1;
                end else begin
                    mem_we = memw_m;
                end
            end
            BEAT: begin
                mem_addr  = clamp_addr(beat_addr);
                mem_wdata = wdata_q[int'(beat_q)*N +: N];
                mem_we    = store_q;
                rdata_m   = result_q;
                stall     = 1'b1;
            end
            DONE: begin
                rdata_m = result_q;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer with a word-addressed behavioural data memory.
module tb_vector_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         vect_m, memw_m, memtoreg_m;
    logic [31:0]  addr_m;
    logic [127:0] wdata_m;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_addr, mem_wdata;
    logic         mem_we;
    logic [127:0] rdata_m;
    logic         stall, busy, done;
`ifdef VSEQ_ALIGN_CHECK_EN
    logic         err;
`endif

    vector_mem_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .vect_m     (vect_m),
        .memw_m     (memw_m),
        .memtoreg_m (memtoreg_m),
        .addr_m     (addr_m),
        .wdata_m    (wdata_m),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .rdata_m    (rdata_m),
        .stall      (stall),
        .busy       (busy),
        .done       (done)
`ifdef VSEQ_ALIGN_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clk = ~clk;

    // Low 4 KiB is real storage; anything above returns a recognisable address-derived pattern.
    bit [31:0] mem [0:1023];
    assign mem_rdata = (mem_addr < 32'd4096) ? mem[mem_addr[11:2]] : (mem_addr ^ 32'h5A5A0000);

    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'd4096) mem[mem_addr[11:2]] <= mem_wdata;
    end

    typedef struct {
        bit           vld;
        logic [127:0] v;
    } rd_exp_t;

    logic [63:0] exp_wr [$];
    rd_exp_t     exp_rd [$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
        logic [31:0] a;
        a = base + 32'(4 * k);
        return (a > 32'h30D3F) ? 32'h0 : a;
    endfunction

    // Scoreboard: every memory write and every done pulse must match the next queued expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        rd_exp_t     r;
        if (rst) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, e[63:32]);
                    chk("wr_data", mem_wdata, e[31:0]);
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_rd.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    r = exp_rd.pop_front();
                    if (r.vld) chk("vec_rdata", rdata_m, r.v);
                end
            end
        end
    end

    task automatic idle_inputs();
        vect_m = 1'b0; memw_m = 1'b0; memtoreg_m = 1'b0;
        addr_m = 32'h0F00; wdata_m = '0;
    endtask

    task automatic scalar_op(input bit st, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_ma);
        vect_m = 1'b0; memw_m = st; memtoreg_m = ~st;
        addr_m = a; wdata_m = {96'h0, d};
        if (st) exp_wr.push_back({exp_ma, d});
        @(negedge clk);
        chk("sc_stall", stall, 0);
        chk("sc_addr", mem_addr, exp_ma);
        if (!st) chk("sc_rdata", rdata_m, {4{d}});
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic vec_access(input bit st, input bit ld, input logic [31:0] base,
                              input logic [127:0] wd, input logic [127:0] exp_v);
        rd_exp_t r;
        vect_m = 1'b1; memw_m = st; memtoreg_m = ld; addr_m = base; wdata_m = wd;
        if (st) for (int i = 0; i < 4; i++) exp_wr.push_back({exp_addr(base, i), wd[32*i +: 32]});
        r.vld = ~st; r.v = exp_v;
        exp_rd.push_back(r);
        @(negedge clk);
        chk("req_stall", stall, 1);
        chk("req_we", mem_we, 0);
        chk("req_busy", busy, 0);
        @(posedge clk); #1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("beat_stall", stall, 1);
            chk("beat_busy", busy, 1);
            chk("beat_addr", mem_addr, exp_addr(base, k));
            chk("beat_we", mem_we, st);
        end
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_pulse", done, 1);
        chk("done_we", mem_we, 0);
    endtask

    initial begin
        int c0;
        int d0;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Preload through scalar pass-through stores
        scalar_op(1, 32'h100, 32'hA5A5A5A5, 32'h100);
        scalar_op(1, 32'h200, 32'h11, 32'h200);
        scalar_op(1, 32'h204, 32'h22, 32'h204);
        scalar_op(1, 32'h208, 32'h33, 32'h208);
        scalar_op(1, 32'h20C, 32'h44, 32'h20C);
        scalar_op(0, 32'h100, 32'hA5A5A5A5, 32'h100);
        scalar_op(0, 32'h40000, 32'h0, 32'h0);

        vec_access(0, 1, 32'h200, '0, 128'h00000044_00000033_00000022_00000011);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        @(posedge clk); #1;

        vec_access(1, 0, 32'h40, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, '0);
        @(posedge clk); #1;
        vec_access(0, 1, 32'h40, '0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        @(posedge clk); #1;

        vec_access(0, 1, 32'h30D3C, '0, {96'h0, 32'h30D3C ^ 32'h5A5A0000});
        @(posedge clk); #1;

        vec_access(1, 1, 32'hC0, 128'h44444444_33333333_22222222_11111111, '0);
        @(posedge clk); #1;
        vec_access(0, 1, 32'hC0, '0, 128'h44444444_33333333_22222222_11111111);
        @(posedge clk); #1;

        // Reset during beat 2 of a store: only lanes 0 and 1 reach memory
        vect_m = 1'b1; memw_m = 1'b1; memtoreg_m = 1'b0; addr_m = 32'h80;
        wdata_m = 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000;
        exp_wr.push_back({32'h80, 32'h0BAD0000});
        exp_wr.push_back({32'h84, 32'h0BAD0001});
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rdata", rdata_m, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vec_access(1, 0, 32'h80, 128'h00000D0D_00000C0C_00000B0B_00000A0A, '0);
        @(posedge clk); #1;
        vec_access(0, 1, 32'h80, '0, 128'h00000D0D_00000C0C_00000B0B_00000A0A);
        @(posedge clk); #1;

        // Back-to-back vector loads
        c0 = cyc;
        d0 = done_cnt;
        vec_access(0, 1, 32'h200, '0, 128'h00000044_00000033_00000022_00000011);
        @(posedge clk); #1;
        vec_access(0, 1, 32'h40, '0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        chk("b2b_cycles", cyc - c0 + 1, 12);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_done_cnt", done_cnt - d0, 2);

        repeat (2) @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
